// File: rtl/im_loader.sv
// im_loader: assembles a host byte stream into instruction words and writes them to the IM from address 0.
// Define IM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte over the payload.
module im_loader #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_vld,
  input  logic [7:0]        byte_in,
  output logic              byte_rdy,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [DATA_W-1:0] im_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [3:0] {
    S_IDLE, S_CNT0, S_CNT1, S_B0, S_B1, S_B2, S_WRITE, S_CSUM, S_DONE, S_ERROR
  } state_t;
  localparam int HB = DATA_W - 16;
  state_t r_state, w_next;
  logic r_byte_rdy, r_we, r_hold, r_busy, r_done, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0] r_wc, w_wc_inc;
  logic [13:0] r_n, w_n;
  logic [7:0] r_b0, r_b1;
  logic [DATA_W-1:0] r_wdata;
  logic w_xfer, w_go, w_n_bad, w_b2_bad, w_last;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0] r_xor;
`endif
  assign w_xfer = byte_vld & r_byte_rdy;
  assign w_n = {byte_in[5:0], r_n[7:0]};
  assign w_n_bad = (w_n == 14'd0) || (32'(w_n) > (32'd1 << ADDR_W));
  assign w_b2_bad = (byte_in >> HB) != 8'd0;
  assign w_wc_inc = r_wc + (ADDR_W+1)'(1);
  assign w_last = 32'(w_wc_inc) == 32'(r_n);
  assign w_go = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: w_next = start ? S_CNT0 : r_state;
      S_CNT0:  w_next = w_xfer ? S_CNT1 : r_state;
      S_CNT1:  w_next = !w_xfer ? r_state : w_n_bad ? S_ERROR : S_B0;
      S_B0:    w_next = w_xfer ? S_B1 : r_state;
      S_B1:    w_next = w_xfer ? S_B2 : r_state;
      S_B2:    w_next = !w_xfer ? r_state : w_b2_bad ? S_ERROR : S_WRITE;
`ifdef IM_LOADER_CHECKSUM_EN
      S_WRITE: w_next = w_last ? S_CSUM : S_B0;
      S_CSUM:  w_next = !w_xfer ? r_state : (byte_in == r_xor) ? S_DONE : S_ERROR;
`else
      S_WRITE: w_next = w_last ? S_DONE : S_B0;
`endif
      default: w_next = S_IDLE;
    endcase
  end
  // outputs are registered decodes of the next state so they line up with r_state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_byte_rdy <= 1'b0;
      r_we <= 1'b0;
      r_hold <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_addr <= '0;
      r_wc <= '0;
      r_n <= '0;
      r_b0 <= '0;
      r_b1 <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      r_byte_rdy <= w_next inside {S_CNT0, S_CNT1, S_B0, S_B1, S_B2, S_CSUM};
      r_we <= w_next == S_WRITE;
      r_hold <= !(w_next inside {S_IDLE, S_DONE});
      r_busy <= !(w_next inside {S_IDLE, S_DONE, S_ERROR});
      r_done <= w_next == S_DONE;
      r_err <= w_next == S_ERROR;
      if (w_go) begin
        r_addr <= '0;
        r_wc <= '0;
      end else if (r_state == S_WRITE) begin
        r_addr <= r_addr + ADDR_W'(1);
        r_wc <= w_wc_inc;
      end
      if (w_xfer && r_state == S_CNT0) r_n[7:0] <= byte_in;
      if (w_xfer && r_state == S_CNT1) r_n[13:8] <= byte_in[5:0];
      if (w_xfer && r_state == S_B0) r_b0 <= byte_in;
      if (w_xfer && r_state == S_B1) r_b1 <= byte_in;
      if (w_xfer && r_state == S_B2 && !w_b2_bad) r_wdata <= DATA_W'({byte_in, r_b1, r_b0});
    end
  end
`ifdef IM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || w_go) r_xor <= '0;
    else if (w_xfer && r_state inside {S_B0, S_B1, S_B2}) r_xor <= r_xor ^ byte_in;
  end
`endif
  assign byte_rdy = r_byte_rdy;
  assign im_we = r_we;
  assign im_waddr = r_addr;
  assign im_wdata = r_wdata;
  assign cpu_hold = r_hold;
  assign busy = r_busy;
  assign done = r_done;
  assign err = r_err;
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: directed tests for im_loader with a write log captured from the IM port.
module tb_im_loader;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, byte_vld = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic byte_rdy, im_we, cpu_hold, busy, done, err;
  logic [12:0] im_waddr;
  logic [19:0] im_wdata;
  int n_chk = 0, n_pass = 0, wr_n = 0, cyc = 0;
  logic [12:0] wr_addr [0:8191];
  logic [19:0] wr_data [0:8191];

  im_loader dut (
    .clk(clk), .rst(rst), .start(start), .byte_vld(byte_vld), .byte_in(byte_in),
    .byte_rdy(byte_rdy), .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (im_we) begin
      wr_addr[wr_n & 8191] <= im_waddr;
      wr_data[wr_n & 8191] <= im_wdata;
      wr_n <= wr_n + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    byte_in = b;
    byte_vld = 1'b1;
    while (!byte_rdy && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) begin
      n_chk++;
      $display("FAIL send_timeout: byte_rdy stayed %b, expected 1 for byte %h", byte_rdy, b);
    end
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_chk++;
    if ({byte_rdy, im_we, cpu_hold, busy, done, err} !== 6'b0)
      $display("FAIL reset_flags: rdy/we/hold/busy/done/err got %b expected 000000", {byte_rdy, im_we, cpu_hold, busy, done, err});
    else n_pass++;
    n_chk++;
    if (im_waddr !== 13'h0) $display("FAIL reset_waddr: got %h expected 0", im_waddr); else n_pass++;
    n_chk++;
    if (im_wdata !== 20'h0) $display("FAIL reset_wdata: got %h expected 0", im_wdata); else n_pass++;
  endtask

  task automatic test_two_word();
    int b = wr_n;
    pulse_start();
    n_chk++;
    if ({byte_rdy, cpu_hold, busy} !== 3'b111)
      $display("FAIL start_rdy: rdy/hold/busy got %b expected 111", {byte_rdy, cpu_hold, busy});
    else n_pass++;
    send(8'h02); send(8'h00); send(8'h34); send(8'h12); send(8'h05);
    n_chk++;
    if ({im_we, im_waddr, im_wdata} !== {1'b1, 13'h0, 20'h51234})
      $display("FAIL word0_write: we/addr/data got %b/%h/%h expected 1/0000/51234", im_we, im_waddr, im_wdata);
    else n_pass++;
    send(8'hFF); send(8'hFF); send(8'h0F);
    n_chk++;
    if ({im_we, im_waddr, im_wdata} !== {1'b1, 13'h1, 20'hFFFFF})
      $display("FAIL word1_write: we/addr/data got %b/%h/%h expected 1/0001/fffff", im_we, im_waddr, im_wdata);
    else n_pass++;
`ifdef IM_LOADER_CHECKSUM_EN
    send(8'h2C);
`else
    tick();
`endif
    byte_vld = 1'b0;
    n_chk++;
    if ({done, cpu_hold, busy, err, byte_rdy} !== 5'b10000)
      $display("FAIL two_word_done: done/hold/busy/err/rdy got %b expected 10000", {done, cpu_hold, busy, err, byte_rdy});
    else n_pass++;
    n_chk++;
    if (wr_n - b !== 2 || wr_data[b & 8191] !== 20'h51234 || wr_data[(b + 1) & 8191] !== 20'hFFFFF || wr_addr[(b + 1) & 8191] !== 13'h1)
      $display("FAIL two_word_log: writes %0d data %h %h, expected 2 writes 51234 fffff", wr_n - b, wr_data[b & 8191], wr_data[(b + 1) & 8191]);
    else n_pass++;
  endtask

  task automatic test_illegal_b2();
    int b = wr_n;
    pulse_start();
    send(8'h01); send(8'h00); send(8'h00); send(8'h00); send(8'h15);
    byte_vld = 1'b0;
    n_chk++;
    if ({err, cpu_hold, busy, byte_rdy, done, im_we} !== 6'b110000)
      $display("FAIL bad_b2: err/hold/busy/rdy/done/we got %b expected 110000", {err, cpu_hold, busy, byte_rdy, done, im_we});
    else n_pass++;
    tick();
    n_chk++;
    if (wr_n !== b) $display("FAIL bad_b2_nowrite: got %0d writes expected 0", wr_n - b); else n_pass++;
  endtask

  task automatic test_zero_count();
    int b = wr_n;
    pulse_start();
    send(8'h00); send(8'h00);
    byte_vld = 1'b0;
    n_chk++;
    if ({err, cpu_hold, busy} !== 3'b110)
      $display("FAIL zero_count: err/hold/busy got %b expected 110", {err, cpu_hold, busy});
    else n_pass++;
    pulse_start();
    n_chk++;
    if ({err, busy, byte_rdy} !== 3'b011)
      $display("FAIL restart_from_err: err/busy/rdy got %b expected 011", {err, busy, byte_rdy});
    else n_pass++;
    send(8'h01); send(8'h20);
    byte_vld = 1'b0;
    n_chk++;
    if ({err, cpu_hold} !== 2'b11) $display("FAIL count_8193: err/hold got %b expected 11", {err, cpu_hold}); else n_pass++;
    tick();
    n_chk++;
    if (wr_n !== b) $display("FAIL bad_count_nowrite: got %0d writes expected 0", wr_n - b); else n_pass++;
  endtask

  task automatic test_full_depth();
    int b = wr_n, t0, t1, t = 0, bad = 0, exp_cyc;
    logic [15:0] a;
    pulse_start();
    t0 = cyc;
    send(8'h00); send(8'h20);
    for (int i = 0; i < 8192; i++) begin
      a = 16'(i);
      send(a[7:0]); send(a[15:8]); send(8'h00);
    end
`ifdef IM_LOADER_CHECKSUM_EN
    send(8'h00);
    exp_cyc = 3 + 4 * 8192;
`else
    exp_cyc = 2 + 4 * 8192;
`endif
    while (!done && t < 20) begin
      tick();
      t++;
    end
    t1 = cyc;
    byte_vld = 1'b0;
    n_chk++;
    if ({done, cpu_hold} !== 2'b10) $display("FAIL full_done: done/hold got %b expected 10", {done, cpu_hold}); else n_pass++;
    n_chk++;
    if (t1 - t0 !== exp_cyc) $display("FAIL full_cycles: got %0d expected %0d", t1 - t0, exp_cyc); else n_pass++;
    n_chk++;
    if (wr_n - b !== 8192) $display("FAIL full_count: got %0d expected 8192", wr_n - b); else n_pass++;
    n_chk++;
    if (wr_addr[(b + 8191) & 8191] !== 13'h1FFF) $display("FAIL full_last_addr: got %h expected 1fff", wr_addr[(b + 8191) & 8191]); else n_pass++;
    for (int i = 0; i < 8192; i++)
      if (wr_addr[(b + i) & 8191] !== 13'(i) || wr_data[(b + i) & 8191] !== 20'(i)) bad++;
    n_chk++;
    if (bad !== 0) $display("FAIL full_data: got %0d bad entries expected 0", bad); else n_pass++;
  endtask

  task automatic test_stall_abort();
    int b = wr_n;
    pulse_start();
    send(8'h03); send(8'h00); send(8'h11); send(8'h22);
    byte_vld = 1'b0;
    repeat (5) tick();
    n_chk++;
    if ({byte_rdy, busy, im_we, err} !== 4'b1100 || wr_n !== b)
      $display("FAIL stall: rdy/busy/we/err got %b writes %0d expected 1100 and 0", {byte_rdy, busy, im_we, err}, wr_n - b);
    else n_pass++;
    send(8'h03);
    n_chk++;
    if ({im_we, im_waddr, im_wdata} !== {1'b1, 13'h0, 20'h32211})
      $display("FAIL stall_write: we/addr/data got %b/%h/%h expected 1/0000/32211", im_we, im_waddr, im_wdata);
    else n_pass++;
    byte_vld = 1'b0;
    tick();
    pulse_start();
    send(8'h44); send(8'h55); send(8'h06);
    n_chk++;
    if ({im_we, im_waddr, im_wdata} !== {1'b1, 13'h1, 20'h65544})
      $display("FAIL start_ignored: we/addr/data got %b/%h/%h expected 1/0001/65544", im_we, im_waddr, im_wdata);
    else n_pass++;
    byte_vld = 1'b0;
    tick();
    send(8'h77);
    byte_vld = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if ({byte_rdy, im_we, cpu_hold, busy, done, err, im_waddr, im_wdata} !== 39'h0)
      $display("FAIL abort_reset: rdy/we/hold/busy/done/err %b addr %h data %h expected all 0",
               {byte_rdy, im_we, cpu_hold, busy, done, err}, im_waddr, im_wdata);
    else n_pass++;
    pulse_start();
    send(8'h01); send(8'h00); send(8'h01); send(8'h02); send(8'h03);
    n_chk++;
    if ({im_we, im_waddr, im_wdata} !== {1'b1, 13'h0, 20'h30201})
      $display("FAIL reload: we/addr/data got %b/%h/%h expected 1/0000/30201", im_we, im_waddr, im_wdata);
    else n_pass++;
`ifdef IM_LOADER_CHECKSUM_EN
    send(8'h00);
`else
    tick();
`endif
    byte_vld = 1'b0;
    n_chk++;
    if ({done, cpu_hold, err} !== 3'b100 || wr_n - b !== 3)
      $display("FAIL reload_done: done/hold/err got %b writes %0d expected 100 and 3", {done, cpu_hold, err}, wr_n - b);
    else n_pass++;
  endtask

`ifdef IM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int b = wr_n;
    pulse_start();
    send(8'h01); send(8'h00); send(8'h34); send(8'h12); send(8'h05); send(8'h23);
    byte_vld = 1'b0;
    n_chk++;
    if ({done, err} !== 2'b10) $display("FAIL csum_good: done/err got %b expected 10", {done, err}); else n_pass++;
    pulse_start();
    send(8'h01); send(8'h00); send(8'h34); send(8'h12); send(8'h05); send(8'h00);
    byte_vld = 1'b0;
    n_chk++;
    if ({done, err, cpu_hold} !== 3'b011 || wr_n - b !== 2)
      $display("FAIL csum_bad: done/err/hold got %b writes %0d expected 011 and 2", {done, err, cpu_hold}, wr_n - b);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_two_word();
    test_illegal_b2();
    test_zero_count();
    test_full_depth();
    test_stall_abort();
`ifdef IM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/im_loader.md
# im_loader

Instruction-memory write-side loader. It accepts a byte stream over a valid/ready handshake and assembles 20-bit instruction words. It writes each word into the 8192 x 20 instruction memory through a dedicated write port, auto-incrementing the address from 0. It sits between the host byte link and the IM write port, and holds the cores in reset while a program image is being loaded.

## Interface
- `ADDR_W`, default 13: instruction memory address width. Depth is 2^ADDR_W.
- `DATA_W`, default 20: instruction word width. It is packed into 3 bytes.
- `clk` input, 1 bit: system clock. All logic is on the rising edge.
- `rst` input, 1 bit: reset. Synchronous, active-high.
- `start` input, 1 bit: one-cycle pulse that begins a load. Honoured only in IDLE, DONE or ERROR.
- `byte_vld` input, 1 bit: host byte valid.
- `byte_in` input, 8 bits: host byte.
- `byte_rdy` output, 1 bit: the loader accepts `byte_in`. A byte transfers on a cycle with `byte_vld & byte_rdy`.
- `im_we` output, 1 bit: IM write enable, a one-cycle pulse.
- `im_waddr` output, ADDR_W bits: IM write address.
- `im_wdata` output, DATA_W bits: IM write data.
- `cpu_hold` output, 1 bit: holds the cores in reset while a load is in progress.
- `busy` output, 1 bit: high in every state except IDLE, DONE and ERROR.
- `done` output, 1 bit: level-high in DONE.
- `err` output, 1 bit: level-high in ERROR.

## Operation
- **Frame format:**
  - `CNT_LO`, `CNT_HI`: word count N, little-endian. Only bits [13:0] are used; `CNT_HI[7:6]` is ignored.
  - N words follow, each as bytes B0, B1, B2, little-endian. The word is {B2[3:0], B1, B0}.
  - With the checksum option, a trailing `CSUM` byte follows the words.
- **States:** IDLE, CNT0, CNT1, B0, B1, B2, WRITE, CSUM, DONE, ERROR.
- **IDLE/DONE/ERROR + `start`:** go to CNT0. Clear the address counter and the word counter. Assert `cpu_hold`.
- **CNT0:** on transfer, latch the count low byte, then go to CNT1.
- **CNT1:** on transfer, latch the count high byte, then check N:
  - N == 0 or N > 2^ADDR_W: go to ERROR.
  - Otherwise: go to B0.
- **B0, B1:** on transfer, latch the byte and advance to the next state.
- **B2:** on transfer, check `B2[7:4]`:
  - `B2[7:4]` != 0: go to ERROR. No write occurs.
  - Otherwise: go to WRITE.
- **WRITE:**
  - Drive `im_we`=1 for exactly one cycle, with the current address and the assembled word.
  - Increment the address and the word counter.
  - If words written == N: go to CSUM when the checksum option is compiled in, otherwise DONE. If not, go to B0.
- **DONE:** deassert `cpu_hold`.
- **ERROR:** `cpu_hold` stays asserted, so the cores do not run a partial image. Leave ERROR only via `start` or `rst`.
- **`byte_rdy`:** 1 in CNT0, CNT1, B0, B1, B2 and CSUM; 0 elsewhere. It is a registered state decode with no combinational path from `byte_vld`.
- **Address counter:** ADDR_W bits.
- **Word counter:** ADDR_W+1 bits, so N = 8192 completes. The last write goes to address 8191. The address wraps to 0 afterwards, but it is unused.
- **`start` while `busy`:** ignored.
- **`rst` at any time, including mid-load:** go to IDLE. All outputs take their reset values. Memory contents already written are not restored.

## Timing
- **Reset values:**
  - `byte_rdy`=0, `im_we`=0, `im_waddr`=0, `im_wdata`=0.
  - `cpu_hold`=0, `busy`=0, `done`=0, `err`=0.
- All outputs are registered.
- **`start` to `byte_rdy`:** `start` sampled at edge k gives `byte_rdy`=1 from cycle k+1.
- **B2 to write:** B2 accepted at edge k gives `im_we`=1 during cycle k+1. The write commits at edge k+2 at the IM's rising-edge write port.
- **Throughput:** a back-to-back stream writes one word per 4 cycles: 3 byte cycles plus 1 WRITE cycle.
- **Error latency:**
  - CNT1 with a bad N, accepted at edge k, gives `err`=1 from cycle k+1.
  - A bad B2 behaves the same way.
- **`byte_vld` low:** the FSM stalls in its current state with no timeout.
- **Read-port hazard:** the IM read port samples on the falling edge. Reads are don't-care while `cpu_hold`=1.

## Configuration
- **`IM_LOADER_CHECKSUM_EN` defined:**
  - A running XOR is kept over all payload bytes B0/B1/B2. It excludes the count bytes.
  - After the last WRITE, go to CSUM and accept one byte.
  - Byte == XOR: go to DONE. Otherwise: go to ERROR. All N writes have already occurred.
- **`IM_LOADER_CHECKSUM_EN` undefined:**
  - The CSUM state and the XOR register are absent.
  - The last WRITE goes directly to DONE.
  - Any following byte is not accepted, because `byte_rdy`=0.

## Test plan
- **Two-word load:** `start`, then bytes 02 00 | 34 12 05 | FF FF 0F. Expect:
  - `im_we` pulses at addr 0 with data 0x51234, then addr 1 with data 0xFFFFF.
  - `done`=1, then `cpu_hold`=0.
- **Illegal B2:** count 01 00, then B2=0x15. Expect `err`=1, `cpu_hold`=1, and no `im_we`.
- **Zero count:** count 00 00. Expect `err`=1 one cycle after CNT1 with no writes. Also count 01 20 (N=8193), with the same expected result.
- **Full depth:** N=8192 (00 20) with pattern data = addr. Expect:
  - 8192 writes, the last at addr 0x1FFF.
  - `done`=1.
  - 4 cycles per word with `byte_vld` held high.
- **Stall and abort:** drop `byte_vld` mid-word; expect no state change. Then:
  - `start` mid-load is ignored.
  - `rst` mid-load gives all outputs 0 and IDLE.
  - A new `start` reloads from addr 0.
- **`IM_LOADER_CHECKSUM_EN`:** payload 34 12 05 with CSUM 0x23 (34^12^05). Expect `done`. With CSUM 0x00: one write occurs, then `err`=1.
